alu_stage: RTL and testbench
============================

# alu_stage

Execute stage of the 16-bit core, between the decode/ALU pipeline buffer (upstream) and the ALU/memory buffer (downstream). It takes the latched decode outputs and selects operands through forwarding muxes. It computes the ALU result and owns the condition-code register (CCR: Z, N, C), including conditional-jump resolution. It saves and restores the CCR around interrupts using a two-state ISR tracker.

## Interface
Parameters:
- DataW, 16, datapath width
- OpW, 4, ALU opcode width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  instruction in stage is real (0 = bubble)
- i_stall  in  1  hold all state this cycle
- i_alu_op  in  OpW  operation (encoding below)
- i_alu_src  in  1  1 = operand B is i_immd
- i_flag_en  in  3  per-flag update mask {C,N,Z}
- i_fwd_a, i_fwd_b  in  2  0 = register, 1 = i_mem_fwd, 2 = i_wb_fwd, 3 = register
- i_read_data1, i_read_data2, i_immd  in  DataW  operands from buffer
- i_mem_fwd, i_wb_fwd  in  DataW  forwarded results
- i_int  in  1  interrupt marker from buffer
- i_rti  in  1  return-from-interrupt
- o_result  out  DataW  ALU result (combinational)
- o_store_data  out  DataW  forwarded operand B before immediate select
- o_jmp_taken  out  1  conditional jump resolves taken (combinational)
- o_ccr  out  3  current {C,N,Z}
- o_in_isr  out  1  ISR state

## Operation
Opcodes:
- 0 NOP: result = A
- 1 MOV: result = B
- 2 ADD: A+B, C = carry out
- 3 SUB: A−B, C = borrow (A<B unsigned)
- 4 AND, 5 OR
- 6 NOT: ~A
- 7 INC: A+1, C = carry
- 8 DEC: A−1, C = borrow
- 9 SHL: A<<immd[3:0], C = last bit out
- 10 SHR: A>>immd[3:0] logical, C = last bit out
- 11 SETC, 12 CLRC: force C
- 13 JZ, 14 JN, 15 JC: result = A

Flag rules:
- Z = (result==0) and N = result[15] update only where i_flag_en has the bit set, and only on op 2–10.
- For SHL/SHR with a shift amount of 0, C is unchanged.
- SETC/CLRC write C regardless of i_flag_en.

Conditional jumps:
- o_jmp_taken = i_valid & tested flag.
- A taken jump clears the tested flag next edge.
- A not-taken jump leaves the CCR unchanged.

ISR tracker FSM:
- IDLE → ISR on i_valid & i_int: CCR copied to saved_ccr.
- In ISR, i_int is ignored (no nesting); saved_ccr is not overwritten.
- ISR → IDLE on i_valid & i_rti: CCR ← saved_ccr.
- i_rti in IDLE: no state change, CCR unchanged.
- i_int and i_rti together in IDLE → ISR (save wins).
- i_int and i_rti together in ISR → IDLE (restore wins).

Gating:
- i_valid=0 or i_stall=1: CCR, saved_ccr and FSM hold. o_result is still driven and o_jmp_taken=0.
- Arithmetic is modulo 2^16 with a 17-bit internal sum for carry/borrow.

## Timing
- o_result, o_store_data and o_jmp_taken are combinational from the inputs, with zero-cycle latency.
- CCR updates on the rising edge after the instruction is presented, and is visible to the next instruction.
- Reset values: CCR=0, saved_ccr=0, FSM=IDLE, o_in_isr=0, o_ccr=0.
- rst has priority over stall and valid.
- Reset in ISR returns to IDLE and discards saved_ccr.
- An interrupt-save edge and a flag update in the same cycle: saved_ccr takes the pre-update CCR, and CCR takes the updated value.
- A restore edge overrides any flag update in the same cycle.

## Structure
- Shared package `core_pkg` holds:
  - opcode constants (ALU_NOP … ALU_JC)
  - forward-select constants (FWD_REG, FWD_MEM, FWD_WB)
  - flag bit indices (FLG_Z=0, FLG_N=1, FLG_C=2)
  - ISR state enum
- One sub-module, `alu_core`: purely combinational op/result/flag-candidate logic.
- `alu_stage` holds the forwarding muxes, CCR, saved_ccr and the FSM.

## Test plan
- ADD 0xFFFF+0x0001 with mask 3'b111 → result 0x0000; next-edge CCR {C,N,Z}=3'b101.
- SUB 0x0003−0x0005 with forward-A from mem (i_mem_fwd=0x0003) → result 0xFFFE, C=1, N=1, Z=0.
- SHL 0x8001 by 1 → 0x0002, C=1. SHL by 0 → C unchanged.
- Z=1, JZ valid → o_jmp_taken=1, Z=0 after edge. JZ again → o_jmp_taken=0.
- Interrupt and return:
  - CCR=3'b110, then i_int → ISR, saved_ccr=3'b110.
  - ADD in the ISR changes the CCR; a second i_int is ignored.
  - i_rti → CCR=3'b110, IDLE.
- Stall and reset:
  - i_stall=1 during ADD → CCR held.
  - rst asserted while in ISR → CCR=0, o_in_isr=0 next edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core execute stage.
// Holds the ALU opcode encoding, forwarding-select codes, condition-code
// bit positions and the ISR tracker state type.
package core_pkg;

    // ALU opcodes
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_MOV  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_NOT  = 4'd6;
    localparam logic [3:0] ALU_INC  = 4'd7;
    localparam logic [3:0] ALU_DEC  = 4'd8;
    localparam logic [3:0] ALU_SHL  = 4'd9;
    localparam logic [3:0] ALU_SHR  = 4'd10;
    localparam logic [3:0] ALU_SETC = 4'd11;
    localparam logic [3:0] ALU_CLRC = 4'd12;
    localparam logic [3:0] ALU_JZ   = 4'd13;
    localparam logic [3:0] ALU_JN   = 4'd14;
    localparam logic [3:0] ALU_JC   = 4'd15;

    // Forwarding selects; code 3 also falls back to the register operand
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Bit positions inside the {C,N,Z} condition-code vector
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;

    // ISR tracker states
    typedef enum logic {
        ISR_IDLE   = 1'b0,
        ISR_ACTIVE = 1'b1
    } isr_state_e;

endpackage

// File: rtl/alu_stage_if.sv
// Bundle of the execute-stage signals between the decode/ALU buffer side
// and the stage itself.
//   master : drives the latched decode fields and forwarded values, observes results
//   slave  : the execute stage (alu_stage)
interface alu_stage_if #(
    parameter int DataW = 16,
    parameter int OpW   = 4
);
    logic             i_valid;
    logic             i_stall;
    logic [OpW-1:0]   i_alu_op;
    logic             i_alu_src;
    logic [2:0]       i_flag_en;
    logic [1:0]       i_fwd_a;
    logic [1:0]       i_fwd_b;
    logic [DataW-1:0] i_read_data1;
    logic [DataW-1:0] i_read_data2;
    logic [DataW-1:0] i_immd;
    logic [DataW-1:0] i_mem_fwd;
    logic [DataW-1:0] i_wb_fwd;
    logic             i_int;
    logic             i_rti;
    logic [DataW-1:0] o_result;
    logic [DataW-1:0] o_store_data;
    logic             o_jmp_taken;
    logic [2:0]       o_ccr;
    logic             o_in_isr;

    modport master (
        output i_valid, i_stall, i_alu_op, i_alu_src, i_flag_en, i_fwd_a, i_fwd_b,
               i_read_data1, i_read_data2, i_immd, i_mem_fwd, i_wb_fwd, i_int, i_rti,
        input  o_result, o_store_data, o_jmp_taken, o_ccr, o_in_isr
    );

    modport slave (
        input  i_valid, i_stall, i_alu_op, i_alu_src, i_flag_en, i_fwd_a, i_fwd_b,
               i_read_data1, i_read_data2, i_immd, i_mem_fwd, i_wb_fwd, i_int, i_rti,
        output o_result, o_store_data, o_jmp_taken, o_ccr, o_in_isr
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: computes the result and, per flag, whether the
// instruction wants to write it and with what value. Jump-flag clearing and
// all state live in alu_stage.
//   op       : opcode
//   a, b     : selected operands (b already includes the immediate select)
//   shamt    : shift amount (low four immediate bits)
//   flag_en  : per-flag update mask {C,N,Z}
//   result   : ALU result
//   flag_we  : {C,N,Z} write enables
//   flag_val : {C,N,Z} candidate values
module alu_core
    import core_pkg::*;
#(
    parameter int DataW = 16,
    parameter int OpW   = 4
) (
    input  logic [OpW-1:0]   op,
    input  logic [DataW-1:0] a,
    input  logic [DataW-1:0] b,
    input  logic [3:0]       shamt,
    input  logic [2:0]       flag_en,
    output logic [DataW-1:0] result,
    output logic [2:0]       flag_we,
    output logic [2:0]       flag_val
);

    localparam logic [DataW:0] ONE_X = {{DataW{1'b0}}, 1'b1};

    // Extra top bit of the wide value carries carry/borrow/shifted-out bit
    logic [DataW:0] wide;
    logic           carry;
    logic           has_carry;
    logic           zn_op;

    always_comb begin
        wide      = '0;
        result    = a;
        carry     = 1'b0;
        has_carry = 1'b0;
        zn_op     = 1'b0;
        case (op)
            ALU_MOV: result = b;
            ALU_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                result    = wide[DataW-1:0];
                carry     = wide[DataW];
                has_carry = 1'b1;
                zn_op     = 1'b1;
            end
            ALU_SUB: begin
                // Top bit of the 17-bit difference is the borrow (A < B)
                wide      = {1'b0, a} - {1'b0, b};
                result    = wide[DataW-1:0];
                carry     = wide[DataW];
                has_carry = 1'b1;
                zn_op     = 1'b1;
            end
            ALU_AND: begin
                result = a & b;
                zn_op  = 1'b1;
            end
            ALU_OR: begin
                result = a | b;
                zn_op  = 1'b1;
            end
            ALU_NOT: begin
                result = ~a;
                zn_op  = 1'b1;
            end
            ALU_INC: begin
                wide      = {1'b0, a} + ONE_X;
                result    = wide[DataW-1:0];
                carry     = wide[DataW];
                has_carry = 1'b1;
                zn_op     = 1'b1;
            end
            ALU_DEC: begin
                wide      = {1'b0, a} - ONE_X;
                result    = wide[DataW-1:0];
                carry     = wide[DataW];
                has_carry = 1'b1;
                zn_op     = 1'b1;
            end
            ALU_SHL: begin
                // Last bit shifted out lands in the spare top bit
                wide      = {1'b0, a} << shamt;
                result    = wide[DataW-1:0];
                carry     = wide[DataW];
                has_carry = (shamt != 4'd0);
                zn_op     = 1'b1;
            end
            ALU_SHR: begin
                // Last bit shifted out lands in the spare bottom bit
                wide      = {a, 1'b0} >> shamt;
                result    = wide[DataW:1];
                carry     = wide[0];
                has_carry = (shamt != 4'd0);
                zn_op     = 1'b1;
            end
            default: result = a;
        endcase
    end

    always_comb begin
        flag_we         = '0;
        flag_val        = '0;
        flag_we[FLG_Z]  = zn_op & flag_en[FLG_Z];
        flag_val[FLG_Z] = (result == '0);
        flag_we[FLG_N]  = zn_op & flag_en[FLG_N];
        flag_val[FLG_N] = result[DataW-1];
        // SETC/CLRC bypass the mask
        flag_we[FLG_C]  = (has_carry & flag_en[FLG_C]) | (op == ALU_SETC) | (op == ALU_CLRC);
        flag_val[FLG_C] = (op == ALU_SETC) ? 1'b1 :
                          (op == ALU_CLRC) ? 1'b0 : carry;
    end

endmodule

// File: rtl/alu_stage.sv
// Execute stage of the 16-bit core: forwarding muxes, ALU, condition-code
// register, conditional-jump resolution and the CCR save/restore around
// interrupts.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : execute-stage signal bundle (slave side)
module alu_stage
    import core_pkg::*;
#(
    parameter int DataW = 16,
    parameter int OpW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_stage_if.slave  bus
);

    logic [DataW-1:0] op_a;
    logic [DataW-1:0] b_fwd;
    logic [DataW-1:0] op_b;
    logic [DataW-1:0] result;
    logic [2:0]       flag_we;
    logic [2:0]       flag_val;
    logic [2:0]       flag_upd;
    logic [2:0]       jmp_clr;
    logic             active;
    logic             jmp_taken;

    logic [2:0]       ccr_reg,   ccr_next;
    logic [2:0]       saved_reg, saved_next;
    isr_state_e       state_reg, state_next;

    always_comb begin
        case (bus.i_fwd_a)
            FWD_MEM: op_a = bus.i_mem_fwd;
            FWD_WB:  op_a = bus.i_wb_fwd;
            default: op_a = bus.i_read_data1;
        endcase
        case (bus.i_fwd_b)
            FWD_MEM: b_fwd = bus.i_mem_fwd;
            FWD_WB:  b_fwd = bus.i_wb_fwd;
            default: b_fwd = bus.i_read_data2;
        endcase
        op_b = bus.i_alu_src ? bus.i_immd : b_fwd;
    end

    alu_core #(
        .DataW (DataW),
        .OpW   (OpW)
    ) u_core (
        .op       (bus.i_alu_op),
        .a        (op_a),
        .b        (op_b),
        .shamt    (bus.i_immd[3:0]),
        .flag_en  (bus.i_flag_en),
        .result   (result),
        .flag_we  (flag_we),
        .flag_val (flag_val)
    );

    assign active = bus.i_valid & ~bus.i_stall;

    // One-hot mask of the flag a jump tests; a taken jump clears that flag
    always_comb begin
        jmp_clr = '0;
        case (bus.i_alu_op)
            ALU_JZ:  jmp_clr[FLG_Z] = 1'b1;
            ALU_JN:  jmp_clr[FLG_N] = 1'b1;
            ALU_JC:  jmp_clr[FLG_C] = 1'b1;
            default: jmp_clr = '0;
        endcase
    end

    assign jmp_taken = active & |(jmp_clr & ccr_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_flag
            assign flag_upd[gi] = (jmp_taken & jmp_clr[gi]) ? 1'b0 :
                                  flag_we[gi]               ? flag_val[gi] : ccr_reg[gi];
        end
    endgenerate

    // A save takes the pre-update CCR while CCR itself still takes the
    // update; a restore overrides any update from the same instruction.
    always_comb begin
        state_next = state_reg;
        ccr_next   = ccr_reg;
        saved_next = saved_reg;
        if (active) begin
            case (state_reg)
                ISR_IDLE: begin
                    if (bus.i_int) begin
                        state_next = ISR_ACTIVE;
                        saved_next = ccr_reg;
                        ccr_next   = flag_upd;
                    end else if (!bus.i_rti) begin
                        ccr_next = flag_upd;
                    end
                end
                default: begin
                    if (bus.i_rti) begin
                        state_next = ISR_IDLE;
                        ccr_next   = saved_reg;
                    end else begin
                        ccr_next = flag_upd;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ISR_IDLE;
            ccr_reg   <= '0;
            saved_reg <= '0;
        end else begin
            state_reg <= state_next;
            ccr_reg   <= ccr_next;
            saved_reg <= saved_next;
        end
    end

    assign bus.o_result     = result;
    assign bus.o_store_data = b_fwd;
    assign bus.o_jmp_taken  = jmp_taken;
    assign bus.o_ccr        = ccr_reg;
    assign bus.o_in_isr     = (state_reg == ISR_ACTIVE);

endmodule

// File: tb/tb_alu_stage.sv
module tb_alu_stage;

    logic clk;
    logic rst;

    alu_stage_if #(.DataW(16), .OpW(4)) bus ();

    alu_stage #(.DataW(16), .OpW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        valid;
        bit        stall;
        bit [3:0]  op;
        bit        src;
        bit [2:0]  fen;
        bit [1:0]  fa;
        bit [1:0]  fb;
        bit [15:0] rd1;
        bit [15:0] rd2;
        bit [15:0] imm;
        bit [15:0] mf;
        bit [15:0] wf;
        bit        intr;
        bit        rti;
    } stim_t;

    typedef struct {
        int       result;
        int       store;
        bit       jmp;
        bit [2:0] ccr;
        bit       isr;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    // Reference model state: flags held by name
    bit m_c, m_n, m_z;
    bit s_c, s_n, s_z;
    bit m_isr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit [1:0] sel, input int reg_v, input int mem_v, input int wb_v);
        if (sel == 2'd1) return mem_v;
        if (sel == 2'd2) return wb_v;
        return reg_v;
    endfunction

    // Computes the expected visible outputs for this cycle and advances the
    // model across the following clock edge.
    task automatic model(input stim_t s, output exp_t e);
        int a, bf, b, sh, r, cy;
        bit hasc, zn, active, flag, jmp;
        bit nc, nn, nz;
        a  = pick(s.fa, int'(s.rd1), int'(s.mf), int'(s.wf));
        bf = pick(s.fb, int'(s.rd2), int'(s.mf), int'(s.wf));
        b  = s.src ? int'(s.imm) : bf;
        sh = int'(s.imm) % 16;
        r = a; cy = 0; hasc = 0;
        zn = (s.op >= 2 && s.op <= 10);
        case (s.op)
            1:  r = b;
            2:  begin r = (a + b) % 65536; cy = (a + b > 65535) ? 1 : 0; hasc = 1; end
            3:  begin r = (a - b + 65536) % 65536; cy = (a < b) ? 1 : 0; hasc = 1; end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = 65535 - a;
            7:  begin r = (a + 1) % 65536; cy = (a == 65535) ? 1 : 0; hasc = 1; end
            8:  begin r = (a + 65535) % 65536; cy = (a == 0) ? 1 : 0; hasc = 1; end
            9:  begin
                    r = (a * (1 << sh)) % 65536;
                    if (sh != 0) begin hasc = 1; cy = (a / (1 << (16 - sh))) % 2; end
                end
            10: begin
                    r = a / (1 << sh);
                    if (sh != 0) begin hasc = 1; cy = (a / (1 << (sh - 1))) % 2; end
                end
            default: r = a;
        endcase
        active = s.valid && !s.stall;
        case (s.op)
            13: flag = m_z;
            14: flag = m_n;
            15: flag = m_c;
            default: flag = 0;
        endcase
        jmp = active && flag;

        e.result = r;
        e.store  = bf;
        e.jmp    = jmp;
        e.ccr    = {m_c, m_n, m_z};
        e.isr    = m_isr;

        nc = m_c; nn = m_n; nz = m_z;
        if (zn && s.fen[0]) nz = (r == 0);
        if (zn && s.fen[1]) nn = (r >= 32768);
        if (hasc && s.fen[2]) nc = (cy != 0);
        if (s.op == 11) nc = 1;
        if (s.op == 12) nc = 0;
        if (jmp) begin
            if (s.op == 13) nz = 0;
            if (s.op == 14) nn = 0;
            if (s.op == 15) nc = 0;
        end

        if (s.rst) begin
            m_c = 0; m_n = 0; m_z = 0;
            s_c = 0; s_n = 0; s_z = 0;
            m_isr = 0;
        end else if (active) begin
            if (!m_isr) begin
                if (s.intr) begin
                    s_c = m_c; s_n = m_n; s_z = m_z;
                    m_c = nc; m_n = nn; m_z = nz;
                    m_isr = 1;
                end else if (!s.rti) begin
                    m_c = nc; m_n = nn; m_z = nz;
                end
            end else begin
                if (s.rti) begin
                    m_c = s_c; m_n = s_n; m_z = s_z;
                    m_isr = 0;
                end else begin
                    m_c = nc; m_n = nn; m_z = nz;
                end
            end
        end
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = s.rst;
        bus.i_valid      = s.valid;
        bus.i_stall      = s.stall;
        bus.i_alu_op     = s.op;
        bus.i_alu_src    = s.src;
        bus.i_flag_en    = s.fen;
        bus.i_fwd_a      = s.fa;
        bus.i_fwd_b      = s.fb;
        bus.i_read_data1 = s.rd1;
        bus.i_read_data2 = s.rd2;
        bus.i_immd       = s.imm;
        bus.i_mem_fwd    = s.mf;
        bus.i_wb_fwd     = s.wf;
        bus.i_int        = s.intr;
        bus.i_rti        = s.rti;
        model(s, e);
        sb.push_back(e);
        $display("[TB] drive rst=%0b v=%0b st=%0b op=%0d a=%04h b=%04h imm=%04h fa=%0d fb=%0d en=%03b int=%0b rti=%0b -> exp res=%04h ccr=%03b isr=%0b",
                 s.rst, s.valid, s.stall, s.op, s.rd1, s.rd2, s.imm, s.fa, s.fb, s.fen, s.intr, s.rti,
                 e.result, e.ccr, e.isr);
    endtask

    function automatic stim_t mk(input bit [3:0] op, input bit [15:0] rd1, input bit [15:0] rd2,
                                 input bit [2:0] fen);
        stim_t s;
        s = '{default: 0};
        s.valid = 1; s.op = op; s.rd1 = rd1; s.rd2 = rd2; s.fen = fen;
        return s;
    endfunction

    function automatic bit [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard monitor: compares each issued transaction's outputs
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result",     32'(bus.o_result),     32'(e.result));
            check("store_data", 32'(bus.o_store_data), 32'(e.store));
            check("jmp_taken",  32'(bus.o_jmp_taken),  32'(e.jmp));
            check("ccr",        32'(bus.o_ccr),        32'(e.ccr));
            check("in_isr",     32'(bus.o_in_isr),     32'(e.isr));
        end
    end

    initial begin
        stim_t s;
        m_c = 0; m_n = 0; m_z = 0; s_c = 0; s_n = 0; s_z = 0; m_isr = 0;
        rst = 1'b1;
        bus.i_valid = 0; bus.i_stall = 0; bus.i_alu_op = 0; bus.i_alu_src = 0;
        bus.i_flag_en = 0; bus.i_fwd_a = 0; bus.i_fwd_b = 0; bus.i_read_data1 = 0;
        bus.i_read_data2 = 0; bus.i_immd = 0; bus.i_mem_fwd = 0; bus.i_wb_fwd = 0;
        bus.i_int = 0; bus.i_rti = 0;
        repeat (3) @(posedge clk);

        // Reset held for one tracked cycle: state must read zero
        s = mk(4'd0, 16'h0, 16'h0, 3'b000); s.rst = 1; s.valid = 0;
        drive(s);
        @(negedge clk);
        check("reset_ccr", 32'(bus.o_ccr), 32'd0);
        check("reset_isr", 32'(bus.o_in_isr), 32'd0);

        s = mk(4'd2, 16'hFFFF, 16'h0001, 3'b111);
        drive(s); @(negedge clk);
        check("add_result", 32'(bus.o_result), 32'h0000);

        s = mk(4'd3, 16'h0000, 16'h0005, 3'b111); s.fa = 2'd1; s.mf = 16'h0003;
        drive(s); @(negedge clk);
        check("add_ccr", 32'(bus.o_ccr), 32'b101);
        check("sub_fwd_result", 32'(bus.o_result), 32'hFFFE);

        s = mk(4'd9, 16'h8001, 16'h0000, 3'b111); s.imm = 16'd1;
        drive(s); @(negedge clk);
        check("sub_ccr", 32'(bus.o_ccr), 32'b110);
        check("shl1_result", 32'(bus.o_result), 32'h0002);

        s = mk(4'd9, 16'h0000, 16'h0000, 3'b111); s.imm = 16'd0;
        drive(s); @(negedge clk);
        check("shl1_ccr", 32'(bus.o_ccr), 32'b100);

        s = mk(4'd13, 16'h1234, 16'h0000, 3'b000);
        drive(s); @(negedge clk);
        check("shl0_ccr", 32'(bus.o_ccr), 32'b101);
        check("jz_taken", 32'(bus.o_jmp_taken), 32'd1);

        drive(s); @(negedge clk);
        check("jz_cleared_ccr", 32'(bus.o_ccr), 32'b100);
        check("jz_not_taken", 32'(bus.o_jmp_taken), 32'd0);

        // Interrupt save / nested ignore / restore
        s = mk(4'd3, 16'h0003, 16'h0005, 3'b111);
        drive(s);
        s = mk(4'd0, 16'h0, 16'h0, 3'b000); s.intr = 1;
        drive(s); @(negedge clk);
        check("pre_int_ccr", 32'(bus.o_ccr), 32'b110);
        s = mk(4'd2, 16'h0001, 16'h0001, 3'b111); s.intr = 1;
        drive(s); @(negedge clk);
        check("isr_entered", 32'(bus.o_in_isr), 32'd1);
        s = mk(4'd0, 16'h0, 16'h0, 3'b000); s.rti = 1;
        drive(s); @(negedge clk);
        check("isr_add_ccr", 32'(bus.o_ccr), 32'b000);
        check("isr_nested_ignored", 32'(bus.o_in_isr), 32'd1);
        s = mk(4'd0, 16'h0, 16'h0, 3'b000);
        drive(s); @(negedge clk);
        check("rti_restored_ccr", 32'(bus.o_ccr), 32'b110);
        check("rti_idle", 32'(bus.o_in_isr), 32'd0);

        // Stall holds the CCR
        s = mk(4'd2, 16'hFFFF, 16'h0001, 3'b111); s.stall = 1;
        drive(s);
        s = mk(4'd0, 16'h0, 16'h0, 3'b000);
        drive(s); @(negedge clk);
        check("stall_ccr", 32'(bus.o_ccr), 32'b110);

        // Reset while in ISR
        s = mk(4'd0, 16'h0, 16'h0, 3'b000); s.intr = 1;
        drive(s);
        s = mk(4'd0, 16'h0, 16'h0, 3'b000); s.rst = 1;
        drive(s); @(negedge clk);
        check("isr_before_rst", 32'(bus.o_in_isr), 32'd1);
        s = mk(4'd0, 16'h0, 16'h0, 3'b000);
        drive(s); @(negedge clk);
        check("rst_in_isr_ccr", 32'(bus.o_ccr), 32'd0);
        check("rst_in_isr_state", 32'(bus.o_in_isr), 32'd0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            s.rst   = ($urandom_range(0, 59) == 0);
            s.valid = ($urandom_range(0, 4) != 0);
            s.stall = ($urandom_range(0, 6) == 0);
            s.op    = 4'($urandom_range(0, 15));
            s.src   = 1'($urandom);
            s.fen   = 3'($urandom);
            s.fa    = 2'($urandom);
            s.fb    = 2'($urandom);
            s.rd1   = rnd16();
            s.rd2   = rnd16();
            s.imm   = 16'($urandom);
            s.mf    = rnd16();
            s.wf    = rnd16();
            s.intr  = ($urandom_range(0, 7) == 0);
            s.rti   = ($urandom_range(0, 7) == 0);
            drive(s);
        end

        s = mk(4'd0, 16'h0, 16'h0, 3'b000); s.valid = 0;
        drive(s);
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
